// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction
// memory and fills the IF/ID register, with stall buffering, redirect discard and misalignment halt.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall_IF,
   input  logic        Branch_taken,
   input  logic [31:0] Branch_dest,
   output logic        IMEM_req,
   output logic [31:0] IMEM_addr,
   input  logic        IMEM_gnt,
   input  logic        IMEM_rvalid,
   input  logic [31:0] IMEM_rdata,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_PC4,
   output logic [31:0] IF_ID_Instr,
   output logic        IF_ID_valid,
   output logic        Misaligned_fault,
   output logic [31:0] Fault_addr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_addr_p0;
   logic [31:0] hold_pc_p0;
   logic [31:0] hold_instr_p0;
   logic        hold_vld_p0;
   logic        discard;
   logic [31:0] if_id_pc_p1;
   logic [31:0] if_id_instr_p1;
   logic        vld_p1;

   logic redirect;
   logic dest_aligned;
   logic grant;
   logic rsp_live;

   assign redirect     = Branch_taken && (state != HALT);
   assign dest_aligned = (Branch_dest[1:0] == 2'b00);
   assign IMEM_req     = (state == REQ) && !Stall_IF && !hold_vld_p0;
   assign IMEM_addr    = pc;
   assign grant        = IMEM_req && IMEM_gnt;
   assign rsp_live     = (state == WAIT) && IMEM_rvalid && !discard;

   assign IF_ID_PC    = if_id_pc_p1;
   assign IF_ID_PC4   = if_id_pc_p1 + 32'd4;
   assign IF_ID_Instr = vld_p1 ? if_id_instr_p1 : NOP_INSTR;
   assign IF_ID_valid = vld_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         pc               <= RESET_PC;
         req_addr_p0      <= RESET_PC;
         hold_pc_p0       <= RESET_PC;
         hold_instr_p0    <= NOP_INSTR;
         hold_vld_p0      <= 1'b0;
         discard          <= 1'b0;
         if_id_pc_p1      <= RESET_PC;
         if_id_instr_p1   <= NOP_INSTR;
         vld_p1           <= 1'b0;
         Misaligned_fault <= 1'b0;
         Fault_addr       <= 32'h0000_0000;
      end else begin
         Misaligned_fault <= 1'b0;
         if (redirect && !dest_aligned) begin
            // Any outstanding response is simply ignored once halted.
            Misaligned_fault <= 1'b1;
            Fault_addr       <= Branch_dest;
            vld_p1           <= 1'b0;
            hold_vld_p0      <= 1'b0;
            discard          <= 1'b0;
            state            <= HALT;
         end else if (redirect) begin
            pc          <= Branch_dest;
            vld_p1      <= 1'b0;
            hold_vld_p0 <= 1'b0;
            if (state == WAIT) begin
               // A response arriving with the redirect is itself the stale one.
               if (IMEM_rvalid) begin
                  discard <= 1'b0;
                  state   <= REQ;
               end else begin
                  discard <= 1'b1;
               end
            end else if (state == REQ && grant) begin
               discard <= 1'b1;
               state   <= WAIT;
            end else if (state == IDLE) begin
               state <= REQ;
            end
         end else begin
            // Fetch buffer -> IF/ID boundary
            if (!Stall_IF) begin
               if (hold_vld_p0) begin
                  if_id_pc_p1    <= hold_pc_p0;
                  if_id_instr_p1 <= hold_instr_p0;
                  vld_p1         <= 1'b1;
                  hold_vld_p0    <= 1'b0;
               end else if (rsp_live) begin
                  if_id_pc_p1    <= req_addr_p0;
                  if_id_instr_p1 <= IMEM_rdata;
                  vld_p1         <= 1'b1;
               end else begin
                  vld_p1 <= 1'b0;
               end
            end else if (rsp_live) begin
               hold_pc_p0    <= req_addr_p0;
               hold_instr_p0 <= IMEM_rdata;
               hold_vld_p0   <= 1'b1;
            end

            case (state)
               IDLE: state <= REQ;
               REQ: begin
                  if (grant) begin
                     req_addr_p0 <= pc;
                     pc          <= pc + 32'd4;
                     state       <= WAIT;
                  end
               end
               WAIT: begin
                  if (IMEM_rvalid) begin
                     discard <= 1'b0;
                     state   <= REQ;
                  end
               end
               default: state <= HALT;
            endcase
         end
      end
   end

endmodule
